tt_um_jk2102: RTL and testbench
===============================

TT_UM_JK2102 -- requirements
Module: tt_um_jk2102

Interface
REQ-001 Parameter: I2C_ADDR, default 7'h55, 7-bit target address this block answers to.
REQ-002 clk  input  1  system clock; all logic is in this single clock domain.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 ena  input  1  block enable; low forces idle.
REQ-005 ui_in  input  8  button/status inputs, returned on I2C reads.
REQ-006 uo_out  output  8  output register, written over I2C.
REQ-007 uio_in  input  8  bit0 = SCL (input only), bit1 = SDA sense; bits 7:2 ignored.
REQ-008 uio_out  output  8  constant 8'h00; SDA is open-drain (bit1 drives 0 only via uio_oe[1]).
REQ-009 uio_oe  output  8  bit1 = 1 pulls SDA low; all other bits constant 0.

Function
REQ-010 SCL and SDA SHALL each pass through a 2-flop synchronizer (reset value 1) before use; edges are detected on the synchronized signals.
REQ-011 Bus timing SHALL be supported for SCL high and low phases of at least 4 clk cycles each.
REQ-012 START = synced SDA falling while synced SCL high; STOP = synced SDA rising while synced SCL high.
REQ-013 States SHALL be IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK.
REQ-014 START in any state SHALL go to ADDR with bit counter cleared; this also applies to a repeated START mid-byte.
REQ-015 STOP in any state SHALL go to IDLE and release SDA.
REQ-016 Received bits SHALL be sampled on SCL rising edges, MSB first.
REQ-017 SDA drive changes SHALL occur only after SCL falling edges.
REQ-018 ADDR: after 8 bits, if bits[7:1] == I2C_ADDR, the block SHALL go to ADDR_ACK and pull SDA low from the 8th SCL falling edge to the 9th SCL falling edge.
REQ-019 ADDR with address mismatch SHALL go to IDLE with SDA released; the block ignores the bus until the next START.
REQ-020 Address bit0 = 0 (write): after ADDR_ACK go to WRITE.
REQ-021 Address bit0 = 1 (read): at the ACK-ending SCL falling edge, load the shift register with ui_in, present bit7, and go to READ.
REQ-022 WRITE: after 8 bits, uo_out SHALL be updated with the byte at the 8th SCL falling edge, followed by an ACK (WRITE_ACK).
REQ-023 Multiple write bytes per transaction SHALL be allowed; each ACKed byte overwrites uo_out.
REQ-024 READ: each SCL falling edge shifts out the next bit; a 1 bit means SDA released, a 0 bit means uio_oe[1] = 1.
REQ-025 After the 8th read bit, SDA SHALL be released and the controller's ACK bit sampled on the 9th SCL rising edge (READ_ACK).
REQ-026 Controller ACK (0) SHALL reload ui_in and continue READ; NACK (1) SHALL go to IDLE.
REQ-027 ena = 0 SHALL hold the FSM in IDLE with SDA released; uo_out keeps its value.
REQ-028 uio_oe[1] SHALL be registered, i.e. glitch-free.

Reset
REQ-029 While rst_n = 0, immediately: uo_out = 8'h00, uio_oe = 8'h00, uio_out = 8'h00, state = IDLE, counters and shift register = 0, synchronizers = 1.
REQ-030 Reset asserted mid-transfer SHALL release SDA at once and abort the transaction; after release, the block waits for a new START.

Verification
REQ-031 Reset -> uo_out = 0x00, uio_oe = 0x00; with ena = 1 and the bus idle high for 100 cycles, outputs stay unchanged.
REQ-032 START, byte 0xAA, data byte 0x3C, STOP (8-clk SCL phases) -> SDA pulled low on both 9th clocks; uo_out = 0x3C after the data byte's 8th SCL falling edge.
REQ-033 START, byte 0xA0 (address mismatch), data 0xFF -> uio_oe[1] never asserted; uo_out unchanged.
REQ-034 ui_in = 0xA5; START, byte 0xAB, read 8 bits, controller NACK, STOP -> address ACKed; read bits = 1,0,1,0,0,1,0,1; SDA released after the byte; FSM in IDLE.
REQ-035 Repeated START after 3 data bits, then 0xAA + 0x81 -> new address ACKed; uo_out = 0x81.
REQ-036 rst_n pulsed low during an ACK low phase -> uio_oe[1] drops to 0 immediately; uo_out = 0x00.

Source files
------------

// File: rtl/tt_um_jk2102.sv
// I2C target with one write register (uo_out) and a read port (ui_in).
// SCL/SDA are oversampled with clk; SDA is driven open-drain through uio_oe[1].
module tt_um_jk2102 #(
    parameter logic [6:0] I2C_ADDR = 7'h55
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StWrite,
        StWriteAck,
        StRead,
        StReadAck
    } state_e;

    logic       r_scl_meta, r_scl_sync, r_scl_prev;
    logic       r_sda_meta, r_sda_sync, r_sda_prev;
    state_e     r_state;
    logic [3:0] r_cnt;
    logic [7:0] r_shift;
    logic       r_rw;
    logic       r_sda_oe;
    logic [7:0] r_uo;

    logic w_scl_rise, w_scl_fall, w_start, w_stop;
    logic w_unused;

    assign w_unused = &{1'b0, uio_in[7:2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_meta <= uio_in[0];
            r_scl_sync <= r_scl_meta;
            r_scl_prev <= r_scl_sync;
            r_sda_meta <= uio_in[1];
            r_sda_sync <= r_sda_meta;
            r_sda_prev <= r_sda_sync;
        end
    end

    assign w_scl_rise = r_scl_sync & ~r_scl_prev;
    assign w_scl_fall = ~r_scl_sync & r_scl_prev;
    // SCL must be high on both samples so an SCL edge is never mistaken for START/STOP.
    assign w_start    = r_scl_sync & r_scl_prev & r_sda_prev & ~r_sda_sync;
    assign w_stop     = r_scl_sync & r_scl_prev & ~r_sda_prev & r_sda_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_cnt    <= 4'd0;
            r_shift  <= 8'h00;
            r_rw     <= 1'b0;
            r_sda_oe <= 1'b0;
            r_uo     <= 8'h00;
        end else if (!ena) begin
            r_state  <= StIdle;
            r_cnt    <= 4'd0;
            r_sda_oe <= 1'b0;
        end else if (w_start) begin
            r_state  <= StAddr;
            r_cnt    <= 4'd0;
            r_sda_oe <= 1'b0;
        end else if (w_stop) begin
            r_state  <= StIdle;
            r_cnt    <= 4'd0;
            r_sda_oe <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_sda_oe <= 1'b0;
                end
                StAddr: begin
                    if (w_scl_rise) begin
                        r_shift <= {r_shift[6:0], r_sda_sync};
                        r_cnt   <= r_cnt + 4'd1;
                    end else if (w_scl_fall && r_cnt == 4'd8) begin
                        r_cnt <= 4'd0;
                        if (r_shift[7:1] == I2C_ADDR) begin
                            r_state  <= StAddrAck;
                            r_rw     <= r_shift[0];
                            r_sda_oe <= 1'b1;
                        end else begin
                            r_state <= StIdle;
                        end
                    end
                end
                StAddrAck: begin
                    if (w_scl_fall) begin
                        if (r_rw) begin
                            r_shift  <= ui_in;
                            r_sda_oe <= ~ui_in[7];
                            r_cnt    <= 4'd1;
                            r_state  <= StRead;
                        end else begin
                            r_sda_oe <= 1'b0;
                            r_cnt    <= 4'd0;
                            r_state  <= StWrite;
                        end
                    end
                end
                StWrite: begin
                    if (w_scl_rise) begin
                        r_shift <= {r_shift[6:0], r_sda_sync};
                        r_cnt   <= r_cnt + 4'd1;
                    end else if (w_scl_fall && r_cnt == 4'd8) begin
                        r_uo     <= r_shift;
                        r_sda_oe <= 1'b1;
                        r_cnt    <= 4'd0;
                        r_state  <= StWriteAck;
                    end
                end
                StWriteAck: begin
                    if (w_scl_fall) begin
                        r_sda_oe <= 1'b0;
                        r_state  <= StWrite;
                    end
                end
                StRead: begin
                    // r_cnt counts bits already presented; bit 7 went out on entry.
                    if (w_scl_fall) begin
                        if (r_cnt == 4'd8) begin
                            r_sda_oe <= 1'b0;
                            r_cnt    <= 4'd0;
                            r_state  <= StReadAck;
                        end else begin
                            r_shift  <= {r_shift[6:0], 1'b0};
                            r_sda_oe <= ~r_shift[6];
                            r_cnt    <= r_cnt + 4'd1;
                        end
                    end
                end
                StReadAck: begin
                    if (w_scl_rise && r_sda_sync) begin
                        r_state <= StIdle;
                    end else if (w_scl_fall) begin
                        r_shift  <= ui_in;
                        r_sda_oe <= ~ui_in[7];
                        r_cnt    <= 4'd1;
                        r_state  <= StRead;
                    end
                end
                default: begin
                    r_state  <= StIdle;
                    r_sda_oe <= 1'b0;
                end
            endcase
        end
    end

    assign uo_out  = r_uo;
    assign uio_out = 8'h00;
    assign uio_oe  = {6'b000000, r_sda_oe, 1'b0};

endmodule

// File: tb/tb_tt_um_jk2102.sv
// Bench for tt_um_jk2102: bit-banged I2C controller with a scoreboard that checks
// the SDA level in every SCL high phase and every change of uo_out.
module tb_tt_um_jk2102;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    logic scl_drv = 1'b1;
    logic sda_low = 1'b0;
    logic sda_line;
    logic mon_en  = 1'b0;
    logic oe_watch = 1'b0;
    logic oe_seen  = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    bit    sda_q[$];
    string sda_tag_q[$];
    logic [7:0] uo_q[$];

    assign sda_line = ~(sda_low | uio_oe[1]);
    assign uio_in   = {6'b000000, sda_line, scl_drv};

    tt_um_jk2102 #(.I2C_ADDR(7'h55)) dut (
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (oe_watch && uio_oe[1]) oe_seen <= 1'b1;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_sda(input bit v, input string tag);
        sda_q.push_back(v);
        sda_tag_q.push_back(tag);
    endtask

    // One SCL clock: set SDA during the low phase, then a high phase the monitor samples.
    task automatic send_bit(input bit b, input bit exp, input string tag);
        sda_low = ~b;
        wclk(8);
        push_sda(exp, tag);
        scl_drv = 1'b1;
        wclk(8);
        scl_drv = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input bit ack_exp, input string tag);
        for (int i = 7; i >= 0; i--) send_bit(v[i], v[i], tag);
        send_bit(1'b1, ack_exp, {tag, "_ack"});
    endtask

    task automatic read_byte(input logic [7:0] exp, input bit ctrl_ack);
        for (int i = 7; i >= 0; i--) send_bit(1'b1, exp[i], "rd_bit");
        send_bit(ctrl_ack, ctrl_ack, "rd_ctrl_ack");
    endtask

    task automatic i2c_start();
        if (scl_drv == 1'b0) begin
            sda_low = 1'b0;
            wclk(8);
            push_sda(1'b1, "rstart_high");
            scl_drv = 1'b1;
        end
        wclk(8);
        sda_low = 1'b1;
        wclk(8);
        scl_drv = 1'b0;
    endtask

    task automatic i2c_stop();
        sda_low = 1'b1;
        wclk(8);
        push_sda(1'b0, "stop_low");
        scl_drv = 1'b1;
        wclk(8);
        sda_low = 1'b0;
        wclk(8);
    endtask

    // SDA monitor: one expectation per SCL high phase.
    initial begin
        bit    e;
        string t;
        wait (mon_en);
        forever begin
            @(posedge scl_drv);
            wclk(4);
            if (sda_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sda_unexpected: got %b, expected no SCL pulse", sda_line);
            end else begin
                e = sda_q.pop_front();
                t = sda_tag_q.pop_front();
                check(t, {7'b0, sda_line}, {7'b0, e});
            end
        end
    end

    // uo_out monitor: every change must match the next queued value.
    initial begin
        logic [7:0] e;
        wait (mon_en);
        forever begin
            @(uo_out);
            #1;
            if (uo_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL uo_unexpected: got %h, expected no change", uo_out);
            end else begin
                e = uo_q.pop_front();
                check("uo_change", uo_out, e);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish, expected end of test");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        ena   = 1'b0;
        ui_in = 8'h00;
        wclk(3);
        check("rst_uo_out", uo_out, 8'h00);
        check("rst_uio_oe", uio_oe, 8'h00);
        check("rst_uio_out", uio_out, 8'h00);
        rst_n  = 1'b1;
        ena    = 1'b1;
        mon_en = 1'b1;
        oe_watch = 1'b1;
        wclk(100);
        check("idle_uo_out", uo_out, 8'h00);
        check("idle_oe_seen", {7'b0, oe_seen}, 8'h00);
        oe_watch = 1'b0;

        // Write 0x3C to our address
        uo_q.push_back(8'h3C);
        i2c_start();
        send_byte(8'hAA, 1'b0, "wr_addr");
        send_byte(8'h3C, 1'b0, "wr_data");
        check("wr_uo_out", uo_out, 8'h3C);
        i2c_stop();

        // Address mismatch: never drives SDA, uo_out kept
        oe_seen  = 1'b0;
        oe_watch = 1'b1;
        i2c_start();
        send_byte(8'hA0, 1'b1, "mm_addr");
        send_byte(8'hFF, 1'b1, "mm_data");
        i2c_stop();
        oe_watch = 1'b0;
        check("mm_oe_seen", {7'b0, oe_seen}, 8'h00);
        check("mm_uo_out", uo_out, 8'h3C);

        // Read ui_in = 0xA5, controller NACK
        ui_in = 8'hA5;
        i2c_start();
        send_byte(8'hAB, 1'b0, "rd_addr");
        read_byte(8'hA5, 1'b1);
        check("rd_released", uio_oe, 8'h00);
        i2c_stop();
        check("rd_idle_oe", uio_oe, 8'h00);

        // Repeated START mid-byte, then write 0x81
        i2c_start();
        send_byte(8'hAA, 1'b0, "rs_addr1");
        send_bit(1'b1, 1'b1, "rs_part");
        send_bit(1'b0, 1'b0, "rs_part");
        send_bit(1'b1, 1'b1, "rs_part");
        i2c_start();
        send_byte(8'hAA, 1'b0, "rs_addr2");
        uo_q.push_back(8'h81);
        send_byte(8'h81, 1'b0, "rs_data");
        i2c_stop();
        check("rs_uo_out", uo_out, 8'h81);

        // Reset during the address ACK low phase
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(1'(8'hAA >> i), 1'(8'hAA >> i), "ra_addr");
        sda_low = 1'b0;
        wclk(6);
        check("ra_ack_driven", {7'b0, uio_oe[1]}, 8'h01);
        uo_q.push_back(8'h00);
        rst_n = 1'b0;
        #1;
        check("ra_oe_dropped", uio_oe, 8'h00);
        check("ra_uo_cleared", uo_out, 8'h00);
        wclk(2);
        rst_n = 1'b1;
        wclk(4);
        push_sda(1'b1, "ra_release");
        scl_drv = 1'b1;
        wclk(8);

        // Fresh transaction after reset recovery
        uo_q.push_back(8'h5A);
        i2c_start();
        send_byte(8'hAA, 1'b0, "post_addr");
        send_byte(8'h5A, 1'b0, "post_data");
        i2c_stop();
        check("post_uo_out", uo_out, 8'h5A);

        wclk(20);
        check("sda_q_drained", 8'(sda_q.size()), 8'h00);
        check("uo_q_drained", 8'(uo_q.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
